// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and next-state action selector
// Revision: 1.0
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_UP   = 2'd2,
    ACT_DOWN = 2'd3
  } act_e;

endpackage

`default_nettype wire

// File: rtl/flipflop_t.sv
// flipflop_t: single-bit T flip-flop with asynchronous active-high reset
// Revision: 1.0
`default_nettype none

module flipflop_t (
  input  logic Clock,
  input  logic reset,
  input  logic T,
  output logic Q
);

  logic t_q;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      t_q <= 1'b0;
    end else if (T) begin
      t_q <= ~t_q;
    end
  end

  assign Q = t_q;

endmodule

`default_nettype wire

// File: rtl/up_down_counter_n.sv
// up_down_counter_n: loadable up/down counter built from T flip-flops, wrap or saturate at 0/MAX_VAL
// Revision: 1.0
`default_nettype none

module up_down_counter_n
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter int          SATURATE = 0
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_MAX = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;
  act_e             act;

  assign at_max  = (count_q == C_MAX);
  assign at_zero = (count_q == '0);

  always_comb begin
    act = ACT_HOLD;
    if (load) begin
      act = ACT_LOAD;
    end else if (en) begin
      act = (x == DIR_UP) ? ACT_UP : ACT_DOWN;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (act)
      ACT_LOAD: count_d = (d > C_MAX) ? C_MAX : d;
      ACT_UP: begin
        if (!at_max) begin
          count_d = count_q + C_ONE;
        end else if (SATURATE == MODE_WRAP) begin
          count_d = '0;
        end
      end
      ACT_DOWN: begin
        if (!at_zero) begin
          count_d = count_q - C_ONE;
        end else if (SATURATE == MODE_WRAP) begin
          count_d = C_MAX;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Each T flop toggles exactly on the bits that differ from the desired next value.
  assign toggle = count_d ^ count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    flipflop_t u_ff (
      .Clock (Clock),
      .reset (reset),
      .T     (toggle[i]),
      .Q     (count_q[i])
    );
  end

  assign tc = en & ~load & ((x & at_max) | (~x & at_zero));

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign Q    = count_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_up_down_counter_n.sv
// tb_up_down_counter_n: directed scenarios on three counter configurations
// Revision: 1.0
`default_nettype none

module tb_up_down_counter_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // A: WIDTH=4, MAX_VAL=9, wrap
  logic       a_en = 1'b0, a_x = 1'b0, a_load = 1'b0;
  logic [3:0] a_d = '0;
  logic [3:0] a_Q;
  logic       a_tc, a_wrap;
  // B: WIDTH=4, MAX_VAL=12, saturate
  logic       b_en = 1'b0, b_x = 1'b0, b_load = 1'b0;
  logic [3:0] b_d = '0;
  logic [3:0] b_Q;
  logic       b_tc, b_wrap;
  // C: WIDTH=8, MAX_VAL=255, wrap
  logic       c_en = 1'b0, c_x = 1'b0, c_load = 1'b0;
  logic [7:0] c_d = '0;
  logic [7:0] c_Q;
  logic       c_tc, c_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  up_down_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_a (
    .Clock(clk), .reset(rst), .en(a_en), .x(a_x), .load(a_load), .d(a_d),
    .Q(a_Q), .tc(a_tc), .wrap(a_wrap)
  );

  up_down_counter_n #(.WIDTH(4), .MAX_VAL(12), .SATURATE(1)) u_b (
    .Clock(clk), .reset(rst), .en(b_en), .x(b_x), .load(b_load), .d(b_d),
    .Q(b_Q), .tc(b_tc), .wrap(b_wrap)
  );

  up_down_counter_n #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) u_c (
    .Clock(clk), .reset(rst), .en(c_en), .x(c_x), .load(c_load), .d(c_d),
    .Q(c_Q), .tc(c_tc), .wrap(c_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    a_en = 1'b1;
    a_x  = 1'b0;
    #2;
    n_checks++;
    if (a_Q !== 4'd0 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: Q=%0d wrap=%0b, expected Q=0 wrap=0", a_Q, a_wrap);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (a_Q !== 4'd0 || a_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: Q=%0d wrap=%0b, expected Q=0 wrap=0", i, a_Q, a_wrap);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_tc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_tc: tc=%0b, expected 1", a_tc);
    end
    tick();
    n_checks++;
    if (a_Q !== 4'd9 || a_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_wrap: Q=%0d wrap=%0b, expected Q=9 wrap=1", a_Q, a_wrap);
    end
    a_en = 1'b0;
  endtask

  task automatic test_count_up();
    int         n_wraps;
    logic [3:0] exp_q;
    a_load = 1'b1;
    a_d    = 4'd0;
    tick();
    a_load = 1'b0;
    a_en   = 1'b1;
    a_x    = 1'b1;
    n_wraps = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (a_tc !== (i == 9)) begin
        n_fail++;
        $display("FAIL up_tc[%0d]: tc=%0b, expected %0b", i, a_tc, (i == 9));
      end
      tick();
      exp_q = 4'((i + 1) % 10);
      if (a_wrap === 1'b1) n_wraps++;
      n_checks++;
      if (a_Q !== exp_q || a_wrap !== (i == 9)) begin
        n_fail++;
        $display("FAIL up_step[%0d]: Q=%0d wrap=%0b, expected Q=%0d wrap=%0b",
                 i, a_Q, a_wrap, exp_q, (i == 9));
      end
    end
    n_checks++;
    if (n_wraps != 1) begin
      n_fail++;
      $display("FAIL up_wrap_count: %0d pulses, expected 1", n_wraps);
    end
    a_en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q;
    a_load = 1'b1;
    a_d    = 4'd0;
    tick();
    a_load = 1'b0;
    a_en   = 1'b1;
    a_x    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (a_tc !== (i == 0)) begin
        n_fail++;
        $display("FAIL down_tc[%0d]: tc=%0b, expected %0b", i, a_tc, (i == 0));
      end
      tick();
      exp_q = 4'(9 - i);
      n_checks++;
      if (a_Q !== exp_q || a_wrap !== (i == 0)) begin
        n_fail++;
        $display("FAIL down_step[%0d]: Q=%0d wrap=%0b, expected Q=%0d wrap=%0b",
                 i, a_Q, a_wrap, exp_q, (i == 0));
      end
    end
    a_en = 1'b0;
  endtask

  task automatic test_saturate();
    b_load = 1'b1;
    b_d    = 4'd14;
    #1;
    n_checks++;
    if (b_tc !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load_tc: tc=%0b, expected 0", b_tc);
    end
    tick();
    n_checks++;
    if (b_Q !== 4'd12 || b_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clip: Q=%0d wrap=%0b, expected Q=12 wrap=0", b_Q, b_wrap);
    end
    b_load = 1'b0;
    b_en   = 1'b1;
    b_x    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (b_tc !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_tc[%0d]: tc=%0b, expected 1", i, b_tc);
      end
      tick();
      n_checks++;
      if (b_Q !== 4'd12 || b_wrap !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_hold[%0d]: Q=%0d wrap=%0b, expected Q=12 wrap=1", i, b_Q, b_wrap);
      end
    end
    b_en = 1'b0;
  endtask

  task automatic test_load_priority();
    a_load = 1'b1;
    a_d    = 4'd3;
    tick();
    n_checks++;
    if (a_Q !== 4'd3) begin
      n_fail++;
      $display("FAIL prio_preload: Q=%0d, expected 3", a_Q);
    end
    a_en = 1'b1;
    a_x  = 1'b1;
    a_d  = 4'd5;
    #1;
    n_checks++;
    if (a_tc !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_tc: tc=%0b, expected 0", a_tc);
    end
    tick();
    n_checks++;
    if (a_Q !== 4'd5 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load_wins: Q=%0d wrap=%0b, expected Q=5 wrap=0", a_Q, a_wrap);
    end
    a_load = 1'b0;
    a_en   = 1'b0;
  endtask

  task automatic test_async_reset();
    a_load = 1'b1;
    a_d    = 4'd7;
    tick();
    a_load = 1'b0;
    n_checks++;
    if (a_Q !== 4'd7) begin
      n_fail++;
      $display("FAIL areset_preload: Q=%0d, expected 7", a_Q);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_Q !== 4'd0 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: Q=%0d wrap=%0b, expected Q=0 wrap=0", a_Q, a_wrap);
    end
    #1;
    rst  = 1'b0;
    a_en = 1'b1;
    a_x  = 1'b1;
    tick();
    n_checks++;
    if (a_Q !== 4'd1) begin
      n_fail++;
      $display("FAIL areset_resume: Q=%0d, expected 1", a_Q);
    end
    a_en = 1'b0;
  endtask

  task automatic test_direction_toggle();
    logic [7:0] exp_q;
    c_load = 1'b1;
    c_d    = 8'd128;
    tick();
    c_load = 1'b0;
    c_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_x = (i % 2 == 0);
      #1;
      n_checks++;
      if (c_tc !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle_tc[%0d]: tc=%0b, expected 0", i, c_tc);
      end
      tick();
      exp_q = (i % 2 == 0) ? 8'd129 : 8'd128;
      n_checks++;
      if (c_Q !== exp_q || c_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle_step[%0d]: Q=%0d wrap=%0b, expected Q=%0d wrap=0",
                 i, c_Q, c_wrap, exp_q);
      end
    end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_priority();
    test_async_reset();
    test_direction_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
